// File: rtl/seq_adder_pkg.sv
// Shared constants and state encoding for the sequential chunked adder.
// Used by seq_chunk_adder and chunk_adder.
package seq_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full adders.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a_s[i] ^ b_s[i] ^ c[i];
        assign c[i+1] = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock, with valid/ready on both sides.
// Optional macro SEQ_ADDER_SATURATE_EN clamps the result on signed overflow.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             c_msb_in;
    logic             last;
    logic             ovf;

    assign a_s  = a_r[int'(idx)*CHUNK +: CHUNK];
    assign b_s  = b_r[int'(idx)*CHUNK +: CHUNK];
    assign last = (idx == LAST_IDX);
    // Only meaningful on the last slice, where the slice MSB is the word MSB.
    assign ovf  = c_msb_in ^ cout;

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a_s      (a_s),
        .b_s      (b_s),
        .cin      (c_r),
        .s        (s),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        c_r      <= sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= s;
                    c_r <= cout;
                    idx <= idx + 1'b1;
                    if (last) begin
                        idx       <= '0;
                        carry_out <= cout;
                        overflow  <= ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SEQ_ADDER_SATURATE_EN
                        // Overflow implies both operand MSBs agree; clamp toward their sign.
                        if (ovf)
                            sum <= a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4) with directed vectors.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got sum=%h with empty scoreboard", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (sum !== e.sum || carry_out !== e.co || overflow !== e.ov) begin
                    failures++;
                    $display("FAIL result: got sum=%h co=%b ov=%b expected sum=%h co=%b ov=%b",
                             sum, carry_out, overflow, e.sum, e.co, e.ov);
                end
            end
        end
    end

    // Issue one operation and verify the exact NCHUNK-edge latency.
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic ts, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1; b = '1; sub = ~ts;
        for (int i = 1; i < NCHUNK; i++) begin
            @(posedge clk); #1;
        end
        chk("latency_pre", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("latency_hit", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_consume_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts, input exp_t e);
        start_op(ta, tb, ts, e);
        consume();
    endtask

    initial begin
        exp_t sat_add, sat_sub;
`ifdef SEQ_ADDER_SATURATE_EN
        sat_add = '{16'h7FFF, 1'b0, 1'b1};
        sat_sub = '{16'h8000, 1'b1, 1'b1};
`else
        sat_add = '{16'h8000, 1'b0, 1'b1};
        sat_sub = '{16'h7FFF, 1'b1, 1'b1};
`endif
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_flags", {30'b0, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h0003, 16'h0003, 1'b0, '{16'h0006, 1'b0, 1'b0});
        run_op(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
        run_op(16'h7FFF, 16'h0001, 1'b0, sat_add);
        run_op(16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
        run_op(16'h8000, 16'h0001, 1'b1, sat_sub);
        run_op(16'h1234, 16'h1234, 1'b1, '{16'h0000, 1'b1, 1'b0});

        // Backpressure with a new request waiting.
        start_op(16'h1000, 16'h0234, 1'b0, '{16'h1234, 1'b0, 1'b0});
        a = 16'h00FF; b = 16'h0F01; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_sum", {16'b0, sum}, 32'h1234);
            chk("bp_flags", {30'b0, carry_out, overflow}, 32'd0);
        end
        consume();
        chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
        run_op(16'h00FF, 16'h0F01, 1'b0, '{16'h1000, 1'b0, 1'b0});

        // Asynchronous reset with idx=2 in CALC.
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_sum", {16'b0, sum}, 32'd0);
        chk("arst_flags", {30'b0, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
